// File: rtl/gf256mul_rr_arbiter.sv
// rtl/gf256mul_rr_arbiter.sv - round-robin shared GF(2^8) multiplier (poly 0x11D), 2-stage pipeline
module gf256mul_rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int IDW     = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic [NUM_REQ-1:0]   req_valid,
    output logic [NUM_REQ-1:0]   req_ready,
    input  logic [8*NUM_REQ-1:0] req_a,
    input  logic [8*NUM_REQ-1:0] req_b,
    output logic [NUM_REQ-1:0]   res_valid,
    output logic [7:0]           res_data,
    output logic                 busy
);

    localparam logic [IDW-1:0] LAST_IDX = IDW'(NUM_REQ - 1);

    logic [IDW-1:0]     ptr;
    logic               s1_valid;
    logic [IDW-1:0]     s1_id;
    logic [7:0]         s1_a;
    logic [7:0]         s1_b;
    logic               s2_valid;
    logic [IDW-1:0]     s2_id;
    logic [7:0]         s2_data;
    logic               grant_found;
    logic [IDW-1:0]     grant_idx;
    logic [NUM_REQ-1:0] grant_vec;
    logic [7:0]         grant_a;
    logic [7:0]         grant_b;
    logic [7:0]         product;

    // Shift-and-add multiply; each doubling of the partial term is reduced by 0x11D in place.
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] acc;
        logic [7:0] term;
        acc  = '0;
        term = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) acc = acc ^ term;
            term = {term[6:0], 1'b0} ^ (term[7] ? 8'h1D : 8'h00);
        end
        return acc;
    endfunction

    // Two passes give the rotated search order: indices >= ptr first, then the wrapped ones.
    always_comb begin
        grant_vec   = '0;
        grant_idx   = '0;
        grant_found = 1'b0;
        grant_a     = '0;
        grant_b     = '0;
        if (en && rst_n) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!grant_found && req_valid[i] && (IDW'(i) >= ptr)) begin
                    grant_found  = 1'b1;
                    grant_vec[i] = 1'b1;
                    grant_idx    = IDW'(i);
                    grant_a      = req_a[8*i +: 8];
                    grant_b      = req_b[8*i +: 8];
                end
            end
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!grant_found && req_valid[i] && (IDW'(i) < ptr)) begin
                    grant_found  = 1'b1;
                    grant_vec[i] = 1'b1;
                    grant_idx    = IDW'(i);
                    grant_a      = req_a[8*i +: 8];
                    grant_b      = req_b[8*i +: 8];
                end
            end
        end
    end

    assign req_ready = grant_vec;
    assign product   = gf_mul(s1_a, s1_b);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr      <= '0;
            s1_valid <= 1'b0;
            s1_id    <= '0;
            s1_a     <= '0;
            s1_b     <= '0;
            s2_valid <= 1'b0;
            s2_id    <= '0;
            s2_data  <= '0;
        end else begin
            s1_valid <= grant_found;
            if (grant_found) begin
                ptr   <= (grant_idx == LAST_IDX) ? '0 : grant_idx + 1'b1;
                s1_id <= grant_idx;
                s1_a  <= grant_a;
                s1_b  <= grant_b;
            end
            // res_data holds its last product while no result is being delivered.
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_id   <= s1_id;
                s2_data <= product;
            end
        end
    end

    always_comb begin
        res_valid = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            res_valid[i] = s2_valid && (s2_id == IDW'(i));
        end
    end

    assign res_data = s2_data;
    assign busy     = s1_valid | s2_valid;

endmodule
